muxf_rr_arbiter: RTL and testbench



---
 rtl/muxf_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_muxf_rr_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muxf_rr_arbiter.sv
// muxf_rr_arbiter
// Round-robin arbiter that shares one NREQ:1 data mux among NREQ packet
// sources and feeds a one-entry registered output stage.
//
// A grant is decided in IDLE, and the mux select is then held in LOCKED
// until the granted source transfers its LAST beat. The select is O_SEL.
// BUSY reports the FSM state: high in LOCKED, low in IDLE.
//
// Handshake: a beat moves across an interface on a rising CLK edge when
// its valid and ready are both high. Ready never depends on valid.
// REQ_READY is combinational from registered state and O_READY only.
//
// Optional build macro MUXF_RR_ARBITER_STATS_EN adds CNT_CLR and GNT_CNT.
// GNT_CNT holds one saturating 16-bit completed-packet count per source.

module muxf_rr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(NREQ)
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic [NREQ-1:0]          REQ_VALID,
  input  logic [NREQ*DATA_W-1:0]   REQ_DATA,
  input  logic [NREQ-1:0]          REQ_LAST,
  output logic [NREQ-1:0]          REQ_READY,
  output logic                     O_VALID,
  output logic [DATA_W-1:0]        O_DATA,
  output logic                     O_LAST,
  input  logic                     O_READY,
  output logic [SEL_W-1:0]         O_SEL,
  output logic                     BUSY
`ifdef MUXF_RR_ARBITER_STATS_EN
  ,
  input  logic                     CNT_CLR,
  output logic [NREQ*16-1:0]       GNT_CNT
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   ptr;

  // Arbitration scan results.
  logic               win_found;
  logic [SEL_W-1:0]   win_idx;
  int                 cand;
  logic [SEL_W-1:0]   cand_idx;

  // Granted-source view through the mux.
  logic               sel_valid;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_data;
  logic               out_free;
  logic               xfer;

  // Scan ptr+1, ptr+2, ... modulo NREQ. The first valid source wins.
  // The modulo keeps every candidate below NREQ, so unused select codes
  // are never produced when NREQ is not a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(ptr) + k) % NREQ;
      cand_idx = SEL_W'(cand);
      if (!win_found && REQ_VALID[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // The shared data mux. It selects the granted source's beat signals.
  always_comb begin
    sel_valid = REQ_VALID[O_SEL];
    sel_last  = REQ_LAST[O_SEL];
    sel_data  = REQ_DATA[O_SEL*DATA_W +: DATA_W];
  end

  // The output register can take a beat when it is empty or draining now.
  // Only the granted source sees ready, and only while LOCKED.
  always_comb begin
    out_free  = !O_VALID || O_READY;
    REQ_READY = '0;
    if (state == LOCKED && out_free) begin
      REQ_READY[O_SEL] = 1'b1;
    end
    xfer = (state == LOCKED) && sel_valid && out_free;
  end

  assign BUSY = (state == LOCKED);

  // Grant FSM, round-robin pointer and output register.
  // A LAST beat in the output register still drains after the return to
  // IDLE. Arbitration for the next packet runs in parallel with that drain.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state   <= IDLE;
      ptr     <= SEL_W'(NREQ - 1);
      O_SEL   <= '0;
      O_VALID <= 1'b0;
      O_DATA  <= '0;
      O_LAST  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            O_SEL <= win_idx;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer && sel_last) begin
            state <= IDLE;
            ptr   <= O_SEL;
          end
        end
        default: state <= IDLE;
      endcase

      if (xfer) begin
        O_VALID <= 1'b1;
        O_DATA  <= sel_data;
        O_LAST  <= sel_last;
      end else if (O_READY) begin
        O_VALID <= 1'b0;
      end
    end
  end

`ifdef MUXF_RR_ARBITER_STATS_EN
  // Per-source completed-packet counters. They saturate at 16'hFFFF.
  // A clear wins over a LAST transfer in the same cycle.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!RSTN || CNT_CLR) begin
        GNT_CNT[i*16 +: 16] <= '0;
      end else if (xfer && sel_last && (O_SEL == SEL_W'(i)) &&
                   (GNT_CNT[i*16 +: 16] != 16'hFFFF)) begin
        GNT_CNT[i*16 +: 16] <= GNT_CNT[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_muxf_rr_arbiter.sv
// tb_muxf_rr_arbiter
// The bench drives directed and random packet traffic into muxf_rr_arbiter.
// A cycle-level behavioural model predicts every output.
// A beat scoreboard checks end-to-end ordering, with no loss and no
// duplication.
// Define MUXF_RR_ARBITER_STATS_EN to also exercise the packet counters.

module tb_muxf_rr_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = $clog2(NREQ);

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- DUT ----------------
  logic [NREQ-1:0]        REQ_VALID;
  logic [NREQ*DATA_W-1:0] REQ_DATA;
  logic [NREQ-1:0]        REQ_LAST;
  logic [NREQ-1:0]        REQ_READY;
  logic                   O_VALID;
  logic [DATA_W-1:0]      O_DATA;
  logic                   O_LAST;
  logic                   O_READY;
  logic [SEL_W-1:0]       O_SEL;
  logic                   BUSY;
`ifdef MUXF_RR_ARBITER_STATS_EN
  logic                   CNT_CLR;
  logic [NREQ*16-1:0]     GNT_CNT;
`endif

  muxf_rr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .REQ_VALID (REQ_VALID),
    .REQ_DATA  (REQ_DATA),
    .REQ_LAST  (REQ_LAST),
    .REQ_READY (REQ_READY),
    .O_VALID   (O_VALID),
    .O_DATA    (O_DATA),
    .O_LAST    (O_LAST),
    .O_READY   (O_READY),
    .O_SEL     (O_SEL),
    .BUSY      (BUSY)
`ifdef MUXF_RR_ARBITER_STATS_EN
    ,
    .CNT_CLR   (CNT_CLR),
    .GNT_CNT   (GNT_CNT)
`endif
  );

  // ---------------- bench state ----------------
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Per-source pending beats {last, data}, and a per-source valid suppression mask.
  logic [DATA_W:0]   src_q[NREQ][$];
  logic [NREQ-1:0]   hold = '0;

  // Scoreboard of beats accepted from sources and not yet seen at the output.
  logic [DATA_W:0]   exp_q[$];

  // Grant log (sel seen on each rise of BUSY) and its cycle numbers.
  int gnt_log[$];
  int gnt_cyc[$];
  logic prev_busy = 1'b0;

  // Values sampled on the most recent tick.
  logic [NREQ-1:0]   s_ready;
  logic              s_ov, s_ol, s_busy;
  logic [DATA_W-1:0] s_od;
  logic [SEL_W-1:0]  s_sel;

  // Behavioural reference model state.
  logic              m_busy;
  int                m_sel, m_ptr;
  logic              m_ov, m_ol;
  logic [DATA_W-1:0] m_od;
  int                m_cnt[NREQ];

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_sel = 0; m_ptr = NREQ - 1;
    m_ov = 1'b0; m_ol = 1'b0; m_od = '0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        REQ_VALID[i] = 1'b1;
        REQ_LAST[i]  = src_q[i][0][DATA_W];
        REQ_DATA[i*DATA_W +: DATA_W] = src_q[i][0][DATA_W-1:0];
      end else begin
        REQ_VALID[i] = 1'b0;
        REQ_LAST[i]  = 1'b0;
        REQ_DATA[i*DATA_W +: DATA_W] = '0;
      end
    end
  endtask

  task automatic push_pkt(input int r, input int len, input logic [DATA_W-1:0] base);
    for (int b = 0; b < len; b++)
      src_q[r].push_back({(b == len - 1), base + DATA_W'(b)});
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    hold = '0;
    drive_inputs();
  endtask

  // One clock cycle. The task samples and checks at the negedge, advances
  // the model, then drives the next inputs 1 time unit after the posedge.
  task automatic tick();
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] acc;
    logic            m_xfer;
    logic            found;
    int              w;
    @(negedge CLK);
    s_ready = REQ_READY; s_ov = O_VALID; s_od = O_DATA; s_ol = O_LAST;
    s_busy = BUSY; s_sel = O_SEL;

    exp_ready = '0;
    if (m_busy && (!m_ov || O_READY)) exp_ready[m_sel] = 1'b1;
    check("o_valid",   O_VALID,   m_ov);
    check("o_data",    O_DATA,    m_od);
    check("o_last",    O_LAST,    m_ol);
    check("o_sel",     O_SEL,     m_sel);
    check("busy",      BUSY,      m_busy);
    check("req_ready", REQ_READY, exp_ready);
`ifdef MUXF_RR_ARBITER_STATS_EN
    for (int i = 0; i < NREQ; i++) check("gnt_cnt", GNT_CNT[i*16 +: 16], m_cnt[i]);
`endif

    if (s_busy && !prev_busy) begin
      gnt_log.push_back(int'(s_sel));
      gnt_cyc.push_back(cyc);
    end
    prev_busy = s_busy;

    acc = REQ_VALID & REQ_READY;
    if (RSTN) begin
      if (O_VALID && O_READY) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $error("FAIL sb_extra observed=0x%0h expected=none", {O_LAST, O_DATA});
        end else begin
          check("sb_beat", {O_LAST, O_DATA}, exp_q.pop_front());
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) exp_q.push_back({REQ_LAST[i], REQ_DATA[i*DATA_W +: DATA_W]});
    end

    // Model step from the spec rules.
    m_xfer = m_busy && REQ_VALID[m_sel] && exp_ready[m_sel];
    if (!RSTN) begin
      model_reset();
      exp_q.delete();
    end else begin
`ifdef MUXF_RR_ARBITER_STATS_EN
      if (CNT_CLR) begin
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      end else if (m_xfer && REQ_LAST[m_sel] && m_cnt[m_sel] < 65535) begin
        m_cnt[m_sel] = m_cnt[m_sel] + 1;
      end
`endif
      if (m_xfer) begin
        m_od = REQ_DATA[m_sel*DATA_W +: DATA_W];
        m_ol = REQ_LAST[m_sel];
        m_ov = 1'b1;
      end else if (O_READY) begin
        m_ov = 1'b0;
      end
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          w = (m_ptr + k) % NREQ;
          if (!found && REQ_VALID[w]) begin
            found = 1'b1; m_sel = w; m_busy = 1'b1;
          end
        end
      end else if (m_xfer && REQ_LAST[m_sel]) begin
        m_busy = 1'b0;
        m_ptr  = m_sel;
      end
    end

    @(posedge CLK);
    #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) if (acc[i]) void'(src_q[i].pop_front());
    drive_inputs();
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    tick(); tick();
    RSTN = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    REQ_VALID = '0; REQ_DATA = '0; REQ_LAST = '0; O_READY = 1'b1;
`ifdef MUXF_RR_ARBITER_STATS_EN
    CNT_CLR = 1'b0;
`endif
    // Test 1: reset, then idle.
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    RSTN = 1'b1;
    drive_inputs();
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t1_idle", {s_ov, s_ready, s_sel, s_busy}, '0);
    end

    // Test 2: single 3-beat packet from requester 2.
    push_pkt(2, 3, 8'hA1);
    drive_inputs();
    tick(); check("t2_arb_busy", s_busy, 1'b0);
    tick(); check("t2_sel", s_sel, 2); check("t2_busy", s_busy, 1'b1);
            check("t2_ready", s_ready, 4'b0100);
    tick(); check("t2_b0", {s_ov, s_ol, s_od}, {2'b10, 8'hA1});
    tick(); check("t2_b1", {s_ov, s_ol, s_od}, {2'b10, 8'hA2});
    tick(); check("t2_b2", {s_ov, s_ol, s_od}, {2'b11, 8'hA3});
            check("t2_busy_drop", s_busy, 1'b0);
    tick(); check("t2_drained", s_ov, 1'b0);

    // Test 3: round-robin fairness with single-beat packets.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < NREQ; r++) push_pkt(r, 1, DATA_W'(8'h30 + r * 16 + p));
    drive_inputs();
    gnt_log.delete(); gnt_cyc.delete();
    repeat (20) tick();
    check("t3_ngrants", gnt_log.size(), 8);
    for (int j = 0; j < gnt_log.size() && j < 8; j++) begin
      check("t3_order", gnt_log[j], j % NREQ);
      if (j > 0) check("t3_spacing", gnt_cyc[j] - gnt_cyc[j-1], 2);
    end

    // Test 4: backpressure mid-packet.
    do_reset();
    push_pkt(1, 6, 8'h41);
    drive_inputs();
    repeat (4) tick();
    O_READY = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t4_hold_data", {s_ov, s_od}, {1'b1, 8'h43});
      check("t4_ready_low", s_ready, '0);
    end
    O_READY = 1'b1;
    repeat (10) tick();
    check("t4_src_empty", src_q[1].size(), 0);
    check("t4_sb_empty", exp_q.size(), 0);

    // Test 5: lock hold while the granted source pauses.
    do_reset();
    gnt_log.delete(); gnt_cyc.delete();
    push_pkt(1, 4, 8'h51);
    drive_inputs();
    tick();
    push_pkt(0, 2, 8'h61);
    drive_inputs();
    tick(); tick();
    hold[1] = 1'b1;
    drive_inputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t5_lock", {s_busy, s_sel}, {1'b1, 2'd1});
    end
    hold = '0;
    drive_inputs();
    repeat (12) tick();
    check("t5_ngrants", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("t5_first", gnt_log[0], 1);
      check("t5_second", gnt_log[1], 0);
    end

`ifdef MUXF_RR_ARBITER_STATS_EN
    // Test 6: packet counters and clear.
    do_reset();
    for (int p = 0; p < 3; p++) push_pkt(3, 2, DATA_W'(8'h70 + p * 4));
    drive_inputs();
    repeat (20) tick();
    check("t6_cnt3", GNT_CNT[63:48], 16'd3);
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    tick();
    check("t6_clr", GNT_CNT, '0);
`endif

    // Random traffic with backpressure, source pauses and the occasional reset.
    do_reset();
    clear_sources();
    for (int c = 0; c < 800; c++) begin
      O_READY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        int r;
        r = $urandom_range(0, NREQ - 1);
        if (src_q[r].size() < 8)
          push_pkt(r, $urandom_range(1, 4), DATA_W'($urandom_range(0, 255)));
      end
      for (int i = 0; i < NREQ; i++) hold[i] = ($urandom_range(0, 9) == 0);
      RSTN = ($urandom_range(0, 199) != 0);
`ifdef MUXF_RR_ARBITER_STATS_EN
      CNT_CLR = ($urandom_range(0, 59) == 0);
`endif
      drive_inputs();
      tick();
    end
    RSTN = 1'b1;
    O_READY = 1'b1;
    hold = '0;
`ifdef MUXF_RR_ARBITER_STATS_EN
    CNT_CLR = 1'b0;
`endif
    drive_inputs();
    repeat (80) tick();
    check("rand_sb_empty", exp_q.size(), 0);
    check("rand_final_idle", {s_busy, s_ov}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
